prog_loader: RTL and testbench

Program loader and run sequencer for the 9-bit-instruction core. It receives a stream of machine-code words over a valid/ready port and writes them, in order, into the instruction memory starting at address 0. After the last word it raises `core_req` to the core and holds it until the core answers on `core_done`. It sits between the host/testbench side and the core's instruction store and `req`/`done` handshake, and acts as writer and initiator for those two interfaces.

---
 rtl/prog_loader.sv | 130 +++++++++++++
 tb/tb_prog_loader.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Program loader: streams machine-code words into instruction memory from address 0, then
// runs the core via a req/done handshake. Optional run watchdog under `LOADER_TIMEOUT_EN`.
module prog_loader #(
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned INSTR_W        = 9,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               in_valid_i,
  input  logic [INSTR_W-1:0] in_data_i,
  input  logic               in_last_i,
  output logic               in_ready_o,
  output logic               imem_we_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  output logic [INSTR_W-1:0] imem_wdata_o,
  output logic               core_req_o,
  input  logic               core_done_i,
  output logic               busy_o,
  output logic [ADDR_W:0]    load_count_o,
  output logic               run_done_o,
  output logic               err_o
);

  typedef enum logic [2:0] {StIdle, StLoad, StFlush, StRun, StErr} state_e;

  localparam logic [ADDR_W:0] TopAddr = {1'b0, {ADDR_W{1'b1}}};

  state_e               state_q, state_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [INSTR_W-1:0]   wdata_q, wdata_d;
  logic [ADDR_W:0]      count_q, count_d;
  logic                 run_done_q, run_done_d;
  logic                 guard_q, guard_d;
  logic                 accept, at_top, done_ok, tmo_hit, can_start;

  assign accept    = (state_q == StLoad) && in_valid_i;
  assign at_top    = (count_q == TopAddr);
  assign can_start = ((state_q == StIdle) || (state_q == StErr)) && start_i;
  // guard_q is high in the first RUN cycle so a stale done from the previous run is masked
  assign done_ok   = core_done_i && !guard_q;

`ifdef LOADER_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d   = (state_q == StRun) ? tmo_q + 1'b1 : '0;
    tmo_hit = (state_q == StRun) && (tmo_d == TmoW'(TIMEOUT_CYCLES));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) tmo_q <= '0;
    else         tmo_q <= tmo_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign tmo_hit        = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      count_q    <= '0;
      run_done_q <= 1'b0;
      guard_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      count_q    <= count_d;
      run_done_q <= run_done_d;
      guard_q    <= guard_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StErr: if (start_i) state_d = StLoad;
      StLoad: begin
        if (accept) begin
          if (in_last_i)   state_d = StFlush;
          else if (at_top) state_d = StErr;
        end
      end
      StFlush: state_d = StRun;
      StRun: begin
        if (done_ok)      state_d = StIdle;
        else if (tmo_hit) state_d = StErr;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    we_d       = accept;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    count_d    = count_q;
    run_done_d = (state_q == StRun) && done_ok;
    guard_d    = (state_q == StFlush);
    if (accept) begin
      addr_d  = count_q[ADDR_W-1:0];
      wdata_d = in_data_i;
      count_d = count_q + 1'b1;
    end
    if (can_start) count_d = '0;
  end

  always_comb begin
    in_ready_o   = (state_q == StLoad);
    core_req_o   = (state_q == StRun);
    busy_o       = (state_q == StLoad) || (state_q == StFlush) || (state_q == StRun);
    err_o        = (state_q == StErr);
    imem_we_o    = we_q;
    imem_addr_o  = addr_q;
    imem_wdata_o = wdata_q;
    load_count_o = count_q;
    run_done_o   = run_done_q;
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed scenarios plus randomized traffic compared each
// cycle against a behavioural model of the loader's observable outputs.
module tb_prog_loader;

  localparam int unsigned AW  = 3;
  localparam int unsigned IW  = 9;
  localparam int unsigned TMO = 16;
  localparam int unsigned CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [IW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          core_done = 1'b0;
  logic          in_ready, imem_we, core_req, busy, run_done, err;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_wdata;
  logic [AW:0]   load_count;

  always #5 clk = ~clk;

  prog_loader #(
    .ADDR_W        (AW),
    .INSTR_W       (IW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .start_i     (start),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_last_i   (in_last),
    .in_ready_o  (in_ready),
    .imem_we_o   (imem_we),
    .imem_addr_o (imem_addr),
    .imem_wdata_o(imem_wdata),
    .core_req_o  (core_req),
    .core_done_i (core_done),
    .busy_o      (busy),
    .load_count_o(load_count),
    .run_done_o  (run_done),
    .err_o       (err)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  int wlog[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  wire [21:0] dut_vec = {in_ready, imem_we, imem_addr, imem_wdata, core_req, busy, load_count,
                         run_done, err};

  // Model: tracks what each output must show, from the loader's rules.
  bit          m_ready, m_we, m_req, m_busy, m_rdone, m_err, m_pend, m_guard;
  logic [AW-1:0] m_addr;
  logic [IW-1:0] m_wdata;
  int          m_words, m_runcyc;

  always @(posedge clk) begin
    if (reset) begin
      m_ready = 0; m_we = 0; m_req = 0; m_busy = 0; m_rdone = 0; m_err = 0;
      m_pend = 0; m_guard = 0; m_addr = '0; m_wdata = '0; m_words = 0; m_runcyc = 0;
    end else begin
      m_we = 0;
      m_rdone = 0;
      if (!m_busy) begin
        if (start) begin
          m_ready = 1; m_busy = 1; m_err = 0; m_words = 0;
        end
      end else if (m_ready) begin
        if (in_valid) begin
          m_we = 1;
          m_addr = m_words[AW-1:0];
          m_wdata = in_data;
          m_words++;
          if (in_last) begin
            m_ready = 0; m_pend = 1;
          end else if (m_words == CAP) begin
            m_ready = 0; m_busy = 0; m_err = 1;
          end
        end
      end else if (m_pend) begin
        m_pend = 0; m_req = 1; m_guard = 1; m_runcyc = 0;
      end else begin
        m_runcyc++;
        if (!m_guard && core_done) begin
          m_req = 0; m_busy = 0; m_rdone = 1;
        end
`ifdef LOADER_TIMEOUT_EN
        else if (m_runcyc == TMO) begin
          m_req = 0; m_busy = 0; m_err = 1;
        end
`endif
        m_guard = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [AW:0] cnt;
      cnt = m_words[AW:0];
      check("cycle_outputs", {10'd0, dut_vec},
            {10'd0, m_ready, m_we, m_addr, m_wdata, m_req, m_busy, cnt, m_rdone, m_err});
    end
    if (imem_we === 1'b1) wlog.push_back(int'(imem_addr) * 512 + int'(imem_wdata));
  end

  task automatic start_session();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [IW-1:0] d, input bit last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic finish_run();
    int n;
    repeat (2) @(negedge clk);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    n = 0;
    while (run_done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("run_done_latency", n, 0);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    logic [IW-1:0] words3[3];
    int n;
    bit req_seen;
    words3[0] = 9'h1A5; words3[1] = 9'h0FF; words3[2] = 9'h100;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    check("reset_outputs", {10'd0, dut_vec}, 32'd0);

    // Three-word load with a stale done held high into the first RUN cycle.
    wlog.delete();
    core_done = 1'b1;
    start_session();
    check("ready_after_start", in_ready, 1);
    for (int i = 0; i < 3; i++) send(words3[i], i == 2);
    check("last_write_we", imem_we, 1);
    check("req_low_at_last_write", core_req, 0);
    check("ready_low_after_last", in_ready, 0);
    @(negedge clk);
    check("req_two_after_last", core_req, 1);
    @(negedge clk);
    core_done = 1'b0;
    check("stale_done_ignored", core_req, 1);
    repeat (4) @(negedge clk);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    check("run_done_pulse", run_done, 1);
    check("req_drop_on_done", core_req, 0);
    check("idle_after_done", busy, 0);
    @(negedge clk);
    check("run_done_single", run_done, 0);
    check("load_count_3", load_count, 3);
    check("writes_3", wlog.size(), 3);
    if (wlog.size() == 3) begin
      check("write0", wlog[0], 0 * 512 + 'h1A5);
      check("write1", wlog[1], 1 * 512 + 'h0FF);
      check("write2", wlog[2], 2 * 512 + 'h100);
    end

    // Valid toggling every other cycle.
    wlog.delete();
    start_session();
    for (int i = 0; i < 4; i++) begin
      send(IW'($urandom), i == 3);
      check("req_low_during_load", core_req, 0);
      @(negedge clk);
      check("req_after_gap", core_req, (i == 3) ? 1 : 0);
    end
    check("writes_4", wlog.size(), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++) check("toggle_addr", wlog[i] / 512, i);
    finish_run();

    // Overflow: nine words, last on the ninth.
    wlog.delete();
    start_session();
    req_seen = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_data = IW'(i + 1);
      in_last = (i == 8);
      @(negedge clk);
      if (core_req) req_seen = 1;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (core_req) req_seen = 1;
    end
    check("overflow_writes", wlog.size(), 8);
    check("overflow_err", err, 1);
    check("overflow_no_req", req_seen, 0);
    check("overflow_count", load_count, 8);
    start_session();
    check("start_clears_err", err, 0);
    check("start_from_err_load", in_ready, 1);
    for (int i = 0; i < 8; i++) send(IW'($urandom), i == 7);
    @(negedge clk);
    check("full_legal_req", core_req, 1);
    check("full_legal_no_err", err, 0);
    check("full_legal_count", load_count, 8);
    finish_run();

    // Reset in the same cycle as an accept.
    start_session();
    send(9'h055, 1'b0);
    in_valid = 1'b1;
    in_data = 9'h0AA;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    check("reset_mid_load", {10'd0, dut_vec}, 32'd0);

    // Start while running is ignored.
    start_session();
    send(9'h001, 1'b0);
    send(9'h002, 1'b1);
    @(negedge clk);
    start_session();
    check("start_ignored_req", core_req, 1);
    check("start_ignored_ready", in_ready, 0);
    finish_run();

`ifdef LOADER_TIMEOUT_EN
    start_session();
    send(9'h003, 1'b1);
    @(negedge clk);
    n = 0;
    while (core_req === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("timeout_run_cycles", n, TMO);
    check("timeout_err", err, 1);
    start_session();
    check("timeout_start_clears", err, 0);
    check("timeout_start_load", in_ready, 1);
    send(9'h004, 1'b1);
    @(negedge clk);
    finish_run();
`endif

    // Randomized traffic checked by the model every cycle.
    for (int c = 0; c < 2500; c++) begin
      start     = ($urandom_range(0, 7) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = IW'($urandom);
      in_last   = ($urandom_range(0, 5) == 0);
      core_done = ($urandom_range(0, 4) == 0);
      reset     = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0; core_done = 1'b0; reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
